// File: rtl/game_pkg.sv
// Shared screen geometry, colour/coordinate widths and the sprite FSM state type.
package game_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int COLOUR_W = 3;
    localparam int X_W      = 9;
    localparam int Y_W      = 8;
    localparam int SUM_W    = 10;
    localparam int CNT_W    = 5;

    typedef enum logic [1:0] {
        IDLE,
        ERASE,
        DRAW,
        FINISH
    } state_t;

endpackage

// File: rtl/sprite_scan.sv
// Row-major column/row scanner over an SPR_W x SPR_H sprite; last flags the final pixel.
module sprite_scan
    import game_pkg::*;
#(
    parameter int SPR_W = 10,
    parameter int SPR_H = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic             last
);

    logic col_end;
    logic row_end;

    assign col_end = (col == CNT_W'(SPR_W - 1));
    assign row_end = (row == CNT_W'(SPR_H - 1));
    assign last    = col_end && row_end;

    // Wrapping on the last pixel leaves the counters at zero for the next pass.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            col <= '0;
            row <= '0;
        end else if (enable) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_draw.sv
// Sprite redraw engine: optionally erases the previous position, then draws the new one.
// Define SPRITE_ERASE_EN to build the ERASE pass and old-position storage.
module sprite_draw
    import game_pkg::*;
#(
    parameter int                  SPR_W     = 10,
    parameter int                  SPR_H     = 10,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       moved,
    input  logic [8:0] x_in,
    input  logic [7:0] y_in,
    input  logic [2:0] colour_in,
    output logic       busy,
    output logic       done,
    output logic [8:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot
);

    state_t              state;
    state_t              state_next;
    logic [X_W-1:0]      base_x;
    logic [Y_W-1:0]      base_y;
    logic [COLOUR_W-1:0] colour_q;
    logic [CNT_W-1:0]    col;
    logic [CNT_W-1:0]    row;
    logic                last;
    logic                accept;
    logic                scan_clr;
    logic                scan_en;
    logic                scanning;
    logic                on_screen;
    logic [X_W-1:0]      pix_base_x;
    logic [Y_W-1:0]      pix_base_y;
    logic [COLOUR_W-1:0] pix_colour;
    logic [SUM_W-1:0]    sum_x;
    logic [SUM_W-1:0]    sum_y;

`ifdef SPRITE_ERASE_EN
    logic [X_W-1:0] old_x;
    logic [Y_W-1:0] old_y;
    logic           old_valid;
`endif

    sprite_scan #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_scan (
        .clock  (clock),
        .reset  (reset),
        .clear  (scan_clr),
        .enable (scan_en),
        .col    (col),
        .row    (row),
        .last   (last)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // done is registered out of FINISH, so busy is extended over that pulse.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        scan_clr   = 1'b0;
        scan_en    = 1'b0;
        case (state)
            IDLE: begin
                if (moved && !done) begin
                    accept   = 1'b1;
                    scan_clr = 1'b1;
`ifdef SPRITE_ERASE_EN
                    state_next = old_valid ? ERASE : DRAW;
`else
                    state_next = DRAW;
`endif
                end
            end
`ifdef SPRITE_ERASE_EN
            ERASE: begin
                scan_en = 1'b1;
                if (last) state_next = DRAW;
            end
`endif
            DRAW: begin
                scan_en = 1'b1;
                if (last) state_next = FINISH;
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE) || done;

    always_ff @(posedge clock) begin
        if (reset) begin
            base_x   <= '0;
            base_y   <= '0;
            colour_q <= '0;
        end else if (accept) begin
            base_x   <= x_in;
            base_y   <= y_in;
            colour_q <= colour_in;
        end
    end

`ifdef SPRITE_ERASE_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            old_x     <= '0;
            old_y     <= '0;
            old_valid <= 1'b0;
        end else if (state == FINISH) begin
            old_x     <= base_x;
            old_y     <= base_y;
            old_valid <= 1'b1;
        end
    end

    assign pix_base_x = (state == ERASE) ? old_x : base_x;
    assign pix_base_y = (state == ERASE) ? old_y : base_y;
`else
    assign pix_base_x = base_x;
    assign pix_base_y = base_y;
`endif

    assign scanning   = (state == ERASE) || (state == DRAW);
    assign pix_colour = (state == ERASE) ? BG_COLOUR : colour_q;
    assign sum_x      = {1'b0, pix_base_x} + {5'b0, col};
    assign sum_y      = {2'b0, pix_base_y} + {5'b0, row};
    assign on_screen  = (sum_x < SUM_W'(SCREEN_W)) && (sum_y < SUM_W'(SCREEN_H));

    always_ff @(posedge clock) begin
        if (reset) begin
            done       <= 1'b0;
            plot       <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
        end else begin
            done <= (state == FINISH);
            if (scanning) begin
                plot       <= on_screen;
                vga_x      <= sum_x[X_W-1:0];
                vga_y      <= sum_y[Y_W-1:0];
                vga_colour <= pix_colour;
            end else begin
                plot       <= 1'b0;
                vga_x      <= '0;
                vga_y      <= '0;
                vga_colour <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sprite_draw.sv
// Bench for sprite_draw: per-cycle reference model of the expected output stream plus
// literal scenario checks; expectations follow SPRITE_ERASE_EN when it is defined.
module tb_sprite_draw;

    localparam int          W  = 10;
    localparam int          H  = 10;
    localparam logic [2:0]  BG = 3'b001;

    typedef struct {
        bit busy;
        bit done;
        bit pix;
        bit plot;
        int x;
        int y;
        int c;
    } rec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       moved = 1'b0;
    logic [8:0] x_in = '0;
    logic [7:0] y_in = '0;
    logic [2:0] colour_in = '0;
    logic       busy;
    logic       done;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;

    int   n_pass  = 0;
    int   n_total = 0;
    rec_t q[$];
    bit   last_busy  = 1'b0;
    bit   mold_valid = 1'b0;
    int   mold_x = 0, mold_y = 0, pend_x = 0, pend_y = 0;

    always #5 clock = ~clock;

    sprite_draw #(.SPR_W(W), .SPR_H(H), .BG_COLOUR(BG)) dut (
        .clock      (clock),
        .reset      (reset),
        .moved      (moved),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour_in  (colour_in),
        .busy       (busy),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot)
    );

    task automatic check(input string name, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    endtask

    task automatic push_pixel(input int px, input int py, input int c);
        rec_t r;
        r.busy = 1'b1; r.done = 1'b0; r.pix = 1'b1;
        r.plot = (px < 320) && (py < 240);
        r.x = px % 512; r.y = py % 256; r.c = c;
        q.push_back(r);
    endtask

    // Expected outputs for every cycle from the acceptance edge through the done pulse.
    task automatic push_move(input int x, input int y, input int c);
        rec_t r;
        bit   erase;
`ifdef SPRITE_ERASE_EN
        erase = mold_valid;
`else
        erase = 1'b0;
`endif
        r = '{busy: 1'b1, done: 1'b0, pix: 1'b0, plot: 1'b0, x: 0, y: 0, c: 0};
        q.push_back(r);
        if (erase)
            for (int row = 0; row < H; row++)
                for (int col = 0; col < W; col++)
                    push_pixel(mold_x + col, mold_y + row, int'(BG));
        for (int row = 0; row < H; row++)
            for (int col = 0; col < W; col++)
                push_pixel(x + col, y + row, c);
        r.done = 1'b1;
        q.push_back(r);
        pend_x = x;
        pend_y = y;
    endtask

    task automatic step(input bit m, input int x, input int y, input int c, input bit r);
        rec_t e;
        moved = m; x_in = 9'(x); y_in = 8'(y); colour_in = 3'(c); reset = r;
        if (r) begin
            q.delete();
            mold_valid = 1'b0;
            last_busy  = 1'b0;
        end else if (m && q.size() == 0 && !last_busy) begin
            push_move(x, y, c);
        end
        @(negedge clock);
        if (q.size() > 0) e = q.pop_front();
        else e = '{busy: 1'b0, done: 1'b0, pix: 1'b0, plot: 1'b0, x: 0, y: 0, c: 0};
        if (e.pix && !e.plot)
            check("cycle_ctl", int'({busy, done, plot}), int'({e.busy, e.done, e.plot}));
        else
            check("cycle_out", int'({busy, done, plot, vga_x, vga_y, vga_colour}),
                  int'({e.busy, e.done, e.plot, 9'(e.x), 8'(e.y), 3'(e.c)}));
        if (e.done) begin
            mold_valid = 1'b1;
            mold_x = pend_x;
            mold_y = pend_y;
        end
        last_busy = e.busy;
    endtask

    task automatic run_move(input int x, input int y, input int c, input int max_steps,
                            input int pulse_at, input int reset_at,
                            output int done_at, output int plots, output int dones,
                            output int fx, output int fy, output int lx, output int ly);
        done_at = -1; plots = 0; dones = 0; fx = -1; fy = -1; lx = -1; ly = -1;
        step(1'b1, x, y, c, 1'b0);
        for (int i = 1; i <= max_steps; i++) begin
            step(i == pulse_at, 123, 45, 2, i == reset_at);
            if (plot) begin
                if (plots == 0) begin fx = int'(vga_x); fy = int'(vga_y); end
                lx = int'(vga_x); ly = int'(vga_y);
                plots++;
            end
            if (done) begin
                dones++;
                if (done_at < 0) done_at = i;
            end
        end
    endtask

    initial begin
        int  d, p, n, fx, fy, lx, ly;
        bit  erase_on;
        int  rx, ry;
`ifdef SPRITE_ERASE_EN
        erase_on = 1'b1;
`else
        erase_on = 1'b0;
`endif
        step(1'b0, 0, 0, 0, 1'b1);
        step(1'b0, 0, 0, 0, 1'b1);
        check("reset_busy", int'(busy), 0);
        check("reset_plot", int'(plot), 0);
        step(1'b0, 0, 0, 0, 1'b0);

        run_move(0, 0, 4, 210, -1, -1, d, p, n, fx, fy, lx, ly);
        check("first_done_at", d, 101);
        check("first_plots", p, 100);
        check("first_pixel", fx * 1000 + fy, 0);
        check("first_last_pixel", lx * 1000 + ly, 9009);
        check("first_dones", n, 1);

        run_move(0, 10, 3, 210, -1, -1, d, p, n, fx, fy, lx, ly);
        check("second_done_at", d, erase_on ? 201 : 101);
        check("second_plots", p, erase_on ? 200 : 100);
        check("second_first_pixel", fx * 1000 + fy, erase_on ? 0 : 10);
        check("second_last_pixel", lx * 1000 + ly, 9019);

        run_move(315, 235, 5, 210, -1, -1, d, p, n, fx, fy, lx, ly);
        check("edge_plots", p, erase_on ? 125 : 25);
        check("edge_done_at", d, erase_on ? 201 : 101);
        check("edge_first_pixel", fx * 1000 + fy, erase_on ? 10 : 315235);
        check("edge_last_pixel", lx * 1000 + ly, 319239);

        run_move(50, 60, 6, 210, 40, -1, d, p, n, fx, fy, lx, ly);
        check("ignore_dones", n, 1);
        check("ignore_done_at", d, erase_on ? 201 : 101);
        check("ignore_last_pixel", lx * 1000 + ly, 59069);

        run_move(100, 100, 7, 50, -1, 50, d, p, n, fx, fy, lx, ly);
        check("abort_dones", n, 0);
        check("abort_outputs", int'({busy, done, plot, vga_x, vga_y, vga_colour}), 0);
        run_move(20, 20, 1, 210, -1, -1, d, p, n, fx, fy, lx, ly);
        check("after_abort_done_at", d, 101);
        check("after_abort_first_pixel", fx * 1000 + fy, 20020);

        run_move(200, 30, 2, 210, -1, -1, d, p, n, fx, fy, lx, ly);
        check("back_to_back_done_at", d, erase_on ? 201 : 101);

        for (int i = 0; i < 4000; i++) begin
            rx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(305, 319)) : int'($urandom_range(0, 319));
            ry = ($urandom_range(0, 3) == 0) ? int'($urandom_range(225, 239)) : int'($urandom_range(0, 239));
            step($urandom_range(0, 19) == 0, rx, ry, int'($urandom_range(0, 7)),
                 $urandom_range(0, 999) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
